// File: rtl/sample_byte_serializer.sv
// sample_byte_serializer
//
// Buffers valid input words in a small FIFO and emits each one as a stream of bytes,
// MSB first, over a valid/ready handshake. When an input word arrives while the FIFO
// is full, the word is dropped and a sticky overflow flag is raised.
//
// Optional feature macro: SERIALIZER_CHECKSUM_EN. When it is defined, each word is
// followed by one checksum byte (the XOR of all of the word's bytes).
//
// Ports:
//   i_clk       clock; all logic runs on the rising edge
//   i_rst       synchronous active-high reset
//   i_valid     input word strobe (no upstream backpressure)
//   i_data      input word, sampled when i_valid = 1
//   i_ready     downstream can accept a byte this cycle
//   o_valid     o_data holds a valid byte (registered)
//   o_data      output byte (registered)
//   o_full      FIFO holds DEPTH words
//   o_overflow  sticky: a word was dropped since the last reset
module sample_byte_serializer #(
  parameter int unsigned DATA_WIDTH_IN = 16,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH_IN-1:0] i_data,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int unsigned BYTES = DATA_WIDTH_IN / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StChk} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH_IN-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_overflow;

  // Output side
  state_e                   r_state;
  logic                     r_valid;
  logic [7:0]               r_data;
  logic [DATA_WIDTH_IN-1:0] r_shift;  // remaining bytes of the current word, next one on top
  logic [IDX_W-1:0]         r_idx;    // index of the byte currently presented

  state_e                   w_state_next;
  logic                     w_valid_next;
  logic [7:0]               w_data_next;
  logic [DATA_WIDTH_IN-1:0] w_shift_next;
  logic [IDX_W-1:0]         w_idx_next;
  logic                     w_pop;
  logic                     w_load;

  logic                     w_push;
  logic                     w_drop;
  logic                     w_empty;
  logic                     w_hs;
  logic [DATA_WIDTH_IN-1:0] w_head;

`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0] r_chk;
  logic [7:0] w_chk_next;

  function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH_IN-1:0] word);
    logic [7:0] acc;
    acc = 8'h00;
    for (int unsigned b = 0; b < BYTES; b++) begin
      acc = acc ^ word[b*8 +: 8];
    end
    return acc;
  endfunction
`endif

  // Full check uses the pre-edge count, so a pop on the same edge cannot rescue a word.
  assign w_empty = (r_count == '0);
  assign w_push  = i_valid && (r_count != FULL_CNT);
  assign w_drop  = i_valid && (r_count == FULL_CNT);
  assign w_hs    = r_valid && i_ready;
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_data_next  = r_data;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    w_pop        = 1'b0;
    w_load       = 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
    w_chk_next   = r_chk;
`endif

    case (r_state)
      StIdle: begin
        if (!w_empty) w_load = 1'b1;
      end
      StSend: begin
        if (w_hs) begin
          if (r_idx != LAST_IDX) begin
            w_idx_next   = r_idx + IDX_W'(1);
            w_data_next  = r_shift[DATA_WIDTH_IN-1 -: 8];
            w_shift_next = r_shift << 8;
          end else begin
`ifdef SERIALIZER_CHECKSUM_EN
            w_data_next  = r_chk;
            w_state_next = StChk;
`else
            if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_valid_next = 1'b0;
              w_state_next = StIdle;
            end
`endif
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      StChk: begin
        if (w_hs) begin
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_valid_next = 1'b0;
            w_state_next = StIdle;
          end
        end
      end
`endif
      default: w_state_next = StIdle;
    endcase

    // Pop the head word and present its MSB; shared by the idle start and the
    // back-to-back continuation so consecutive words have no bubble.
    if (w_load) begin
      w_pop        = 1'b1;
      w_state_next = StSend;
      w_valid_next = 1'b1;
      w_data_next  = w_head[DATA_WIDTH_IN-1 -: 8];
      w_shift_next = w_head << 8;
      w_idx_next   = '0;
`ifdef SERIALIZER_CHECKSUM_EN
      w_chk_next   = xor_bytes(w_head);
`endif
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_state    <= StIdle;
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
      r_shift    <= '0;
      r_idx      <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
      r_chk      <= 8'h00;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
      r_state    <= w_state_next;
      r_valid    <= w_valid_next;
      r_data     <= w_data_next;
      r_shift    <= w_shift_next;
      r_idx      <= w_idx_next;
`ifdef SERIALIZER_CHECKSUM_EN
      r_chk      <= w_chk_next;
`endif
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_full     = (r_count == FULL_CNT);
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_sample_byte_serializer.sv
// Self-checking bench for sample_byte_serializer: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_sample_byte_serializer;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BYTES = W / 8;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int unsigned FRAME = BYTES + 1;
`else
  localparam int unsigned FRAME = BYTES;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         vld;
  logic [W-1:0] din;
  logic         rdy;
  logic         o_valid;
  logic [7:0]   o_data;
  logic         o_full;
  logic         o_overflow;

  always #5 clk = ~clk;

  sample_byte_serializer #(
    .DATA_WIDTH_IN(W),
    .DEPTH        (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (vld),
    .i_data    (din),
    .i_ready   (rdy),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of accepted words and the bytes still to send of the current
  // frame (head = byte currently presented).
  logic [W-1:0] m_fifo[$];
  logic [7:0]   m_cur[$];
  bit           m_ovf;
  bit           m_zero;  // o_data known to be 0x00 (since reset, before any byte)
  logic [7:0]   obs[$];  // bytes actually handed off by the DUT

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [W-1:0] w, input int k);
    logic [W-1:0] t;
    logic [7:0]   x;
    if (k < int'(BYTES)) begin
      t = w >> ((int'(BYTES) - 1 - k) * 8);
      return t[7:0];
    end
    x = 8'h00;
    for (int b = 0; b < int'(BYTES); b++) begin
      t = w >> (b * 8);
      x = x ^ t[7:0];
    end
    return x;
  endfunction

  function automatic void model_step(input bit r_st, input bit v, input logic [W-1:0] d,
                                     input bit r);
    bit           full_pre;
    logic [W-1:0] w;
    if (r_st) begin
      m_fifo.delete();
      m_cur.delete();
      m_ovf  = 1'b0;
      m_zero = 1'b1;
      return;
    end
    full_pre = (m_fifo.size() == DEPTH);
    if (m_cur.size() > 0 && r) void'(m_cur.pop_front());
    if (m_cur.size() == 0 && m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      for (int k = 0; k < int'(FRAME); k++) m_cur.push_back(frame_byte(w, k));
    end
    if (v) begin
      if (full_pre) m_ovf = 1'b1;
      else m_fifo.push_back(d);
    end
    if (m_cur.size() > 0) m_zero = 1'b0;
  endfunction

  // Drive one cycle of inputs (called at a negedge), then compare at the next negedge.
  task automatic cycle(input bit r_st, input bit v, input logic [W-1:0] d, input bit r);
    rst = r_st;
    vld = v;
    din = d;
    rdy = r;
    if (!r_st && o_valid === 1'b1 && r) obs.push_back(o_data);
    model_step(r_st, v, d, r);
    @(negedge clk);
    check_eq("o_valid", 32'(o_valid), 32'(m_cur.size() > 0));
    check_eq("o_full", 32'(o_full), 32'(m_fifo.size() == DEPTH));
    check_eq("o_overflow", 32'(o_overflow), 32'(m_ovf));
    if (m_cur.size() > 0) check_eq("o_data", 32'(o_data), 32'(m_cur[0]));
    else if (m_zero) check_eq("o_data_rst", 32'(o_data), 32'h0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, r);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    obs.delete();
  endtask

  task automatic expect_stream(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), 32'(obs[i]), 32'(exp[i]));
    end
  endtask

  function automatic void add_word(inout logic [7:0] q[$], input logic [W-1:0] w);
    for (int k = 0; k < int'(FRAME); k++) q.push_back(frame_byte(w, k));
  endfunction

  initial begin
    logic [7:0] exp[$];
    int         guard;
    int         pv;
    int         pr;

    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    rdy = 1'b0;
    @(negedge clk);
    do_reset();
    check_eq("rst_valid", 32'(o_valid), 32'h0);
    check_eq("rst_data", 32'(o_data), 32'h0);
    check_eq("rst_full", 32'(o_full), 32'h0);
    check_eq("rst_ovf", 32'(o_overflow), 32'h0);

    // Single word: o_valid must rise two cycles after the input strobe.
    cycle(1'b0, 1'b1, 16'h1234, 1'b1);
    check_eq("lat_cycle1", 32'(o_valid), 32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check_eq("lat_cycle2", 32'(o_valid), 32'h1);
    check_eq("lat_msb", 32'(o_data), 32'h12);
    idle(6, 1'b1);
    exp = '{8'h12, 8'h34};
`ifdef SERIALIZER_CHECKSUM_EN
    exp.push_back(8'h26);
`endif
    expect_stream("single", exp);

    // Back-to-back words.
    do_reset();
    cycle(1'b0, 1'b1, 16'hA1B2, 1'b1);
    cycle(1'b0, 1'b1, 16'hC3D4, 1'b1);
    idle(10, 1'b1);
`ifdef SERIALIZER_CHECKSUM_EN
    exp = '{8'hA1, 8'hB2, 8'h13, 8'hC3, 8'hD4, 8'h17};
`else
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
`endif
    expect_stream("b2b", exp);

    // Backpressure holds the MSB.
    do_reset();
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b0);
      check_eq("stall_valid", 32'(o_valid), 32'h1);
      check_eq("stall_data", 32'(o_data), 32'hBE);
    end
    idle(6, 1'b1);
`ifdef SERIALIZER_CHECKSUM_EN
    exp = '{8'hBE, 8'hEF, 8'h51};
`else
    exp = '{8'hBE, 8'hEF};
`endif
    expect_stream("stall", exp);

    // Overflow: the first word moves into the output register, so five words fill
    // the FIFO and the sixth is dropped.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 1'b1, 16'(i), 1'b0);
      if (i == 4) check_eq("ovf_not_full4", 32'(o_full), 32'h0);
      if (i == 5) check_eq("ovf_full5", 32'(o_full), 32'h1);
      if (i == 5) check_eq("ovf_clear5", 32'(o_overflow), 32'h0);
      if (i == 6) check_eq("ovf_set6", 32'(o_overflow), 32'h1);
    end
    idle(30, 1'b1);
    check_eq("ovf_sticky", 32'(o_overflow), 32'h1);
    exp.delete();
    for (int i = 1; i <= 5; i++) add_word(exp, 16'(i));
    expect_stream("ovf", exp);

    // Full FIFO with a pop on the same edge as a new word: word still dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 16'(i * 16'h1111), 1'b0);
    guard = 0;
    while (m_cur.size() > 1 && guard < 16) begin
      idle(1, 1'b1);
      guard++;
    end
    check_eq("popdrop_full", 32'(o_full), 32'h1);
    cycle(1'b0, 1'b1, 16'hDEAD, 1'b1);
    check_eq("popdrop_ovf", 32'(o_overflow), 32'h1);
    check_eq("popdrop_notfull", 32'(o_full), 32'h0);
    idle(30, 1'b1);
    exp.delete();
    for (int i = 1; i <= 5; i++) add_word(exp, 16'(i * 16'h1111));
    expect_stream("popdrop", exp);

    // Reset in the middle of a word.
    do_reset();
    cycle(1'b0, 1'b1, 16'h1234, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check_eq("midrst_msb", 32'(o_data), 32'h12);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check_eq("midrst_valid", 32'(o_valid), 32'h0);
    check_eq("midrst_data", 32'(o_data), 32'h0);
    check_eq("midrst_full", 32'(o_full), 32'h0);
    check_eq("midrst_ovf", 32'(o_overflow), 32'h0);
    obs.delete();
    cycle(1'b0, 1'b1, 16'h5678, 1'b1);
    idle(6, 1'b1);
`ifdef SERIALIZER_CHECKSUM_EN
    exp = '{8'h56, 8'h78, 8'h2E};
`else
    exp = '{8'h56, 8'h78};
`endif
    expect_stream("midrst", exp);

    // Randomized traffic in several load regimes, with occasional resets.
    for (int ph = 0; ph < 4; ph++) begin
      pv = (ph == 0) ? 20 : (ph == 1) ? 60 : (ph == 2) ? 90 : 40;
      pr = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 30 : 100;
      for (int i = 0; i < 1500; i++) begin
        cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pv, 16'($urandom),
              $urandom_range(0, 99) < pr);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
